// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: holds one instruction between EX and WB, waits for variable-latency
// data SRAM returns, extracts sub-word load data, and drops returns owed to flushed loads.
module mem_stage_lsu #(
    parameter int PC_W      = 32,
    parameter int RF_AW     = 5,
    parameter int DISCARD_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             es_to_ms_valid,
    output logic             ms_allowin,
    input  logic [PC_W-1:0]  es_pc,
    input  logic [2:0]       es_load_op,
    input  logic             es_mem_inflight,
    input  logic             es_rf_we,
    input  logic [RF_AW-1:0] es_rf_addr,
    input  logic [31:0]      es_alu_result,
    input  logic             ms_flush,
    input  logic             data_sram_data_ok,
    input  logic [31:0]      data_sram_rdata,
    input  logic             ws_allowin,
    output logic             ms_to_ws_valid,
    output logic [PC_W-1:0]  ms_pc,
    output logic             ms_rf_we,
    output logic [RF_AW-1:0] ms_rf_addr,
    output logic [31:0]      ms_rf_wdata,
    output logic             ms_fwd_valid,
    output logic             ms_fwd_ready
);

    localparam logic [DISCARD_W-1:0] DISCARD_MAX = '1;

    logic                 ms_valid_q;
    logic [PC_W-1:0]      pc_q;
    logic [2:0]           load_op_q;
    logic                 inflight_q;
    logic                 rf_we_q;
    logic [RF_AW-1:0]     rf_addr_q;
    logic [31:0]          alu_q;
    logic                 buf_valid_q;
    logic [31:0]          buf_q;
    logic [DISCARD_W-1:0] discard_q;
    logic [DISCARD_W-1:0] discard_d;

    logic        wait_data;
    logic        data_ok_own;
    logic        data_ok_dis;
    logic        ms_ready_go;
    logic        disc_inc;
    logic        disc_dec;
    logic [31:0] raw;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign wait_data   = ms_valid_q & inflight_q & ~buf_valid_q;
    assign data_ok_own = data_sram_data_ok & (discard_q == '0);
    assign data_ok_dis = data_sram_data_ok & (discard_q != '0);
    assign ms_ready_go = ~wait_data | data_ok_own;

    assign ms_to_ws_valid = ms_valid_q & ms_ready_go & ~ms_flush;
    assign ms_allowin     = (~ms_valid_q | (ms_ready_go & ws_allowin)) & (discard_q != DISCARD_MAX);

    assign ms_pc        = pc_q;
    assign ms_rf_we     = ms_valid_q & rf_we_q;
    assign ms_rf_addr   = rf_addr_q;
    assign ms_fwd_valid = ms_valid_q & rf_we_q;
    assign ms_fwd_ready = ms_ready_go;

    // A flushed load still waiting on its return leaves a stale data_ok behind to swallow.
    assign disc_inc = ms_flush & wait_data & ~data_ok_own;
    assign disc_dec = data_ok_dis;

    always_comb begin
        discard_d = discard_q;
        if (disc_inc && !disc_dec && discard_q != DISCARD_MAX) begin
            discard_d = discard_q + 1'b1;
        end else if (disc_dec && !disc_inc) begin
            discard_d = discard_q - 1'b1;
        end
    end

    always_comb begin
        raw      = buf_valid_q ? buf_q : data_sram_rdata;
        byte_sel = raw[7:0];
        case (alu_q[1:0])
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        half_sel = alu_q[1] ? raw[31:16] : raw[15:0];
        case (load_op_q)
            3'd1:    ms_rf_wdata = {{24{byte_sel[7]}}, byte_sel};
            3'd2:    ms_rf_wdata = {24'h0, byte_sel};
            3'd3:    ms_rf_wdata = {{16{half_sel[15]}}, half_sel};
            3'd4:    ms_rf_wdata = {16'h0, half_sel};
            3'd5:    ms_rf_wdata = raw;
            default: ms_rf_wdata = alu_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q <= 1'b0;
        end else if (ms_flush) begin
            ms_valid_q <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid_q <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q       <= '0;
            load_op_q  <= '0;
            inflight_q <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            alu_q      <= '0;
        end else if (ms_allowin && es_to_ms_valid) begin
            pc_q       <= es_pc;
            load_op_q  <= es_load_op;
            inflight_q <= es_mem_inflight;
            rf_we_q    <= es_rf_we;
            rf_addr_q  <= es_rf_addr;
            alu_q      <= es_alu_result;
        end
    end

    // Capture the return only when WB is stalled; otherwise it passes straight through.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
        end else if (ms_flush) begin
            buf_valid_q <= 1'b0;
        end else if (ms_to_ws_valid && ws_allowin) begin
            buf_valid_q <= 1'b0;
        end else if (data_ok_own && wait_data && !ws_allowin) begin
            buf_valid_q <= 1'b1;
            buf_q       <= data_sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            discard_q <= '0;
        end else begin
            discard_q <= discard_d;
        end
    end

endmodule
